// File: rtl/fifo_pkg.sv
// Shared constants and parameter-legality helpers for the single-clock FIFO family.
// No logic; elaboration-time use only.
// Nothing here carries data, so there is no backpressure to describe.
package fifo_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_DEPTH      = 16;

    // Pointer width: one extra wrap bit over the address width.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic bit is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

    function automatic bit params_legal(input int depth, input int af_thresh, input int ae_thresh);
        return is_pow2(depth) && (depth >= 4)
            && (af_thresh >= 1) && (af_thresh <= depth)
            && (ae_thresh >= 0) && (ae_thresh <= depth - 1);
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_WIDTH register array: synchronous write, asynchronous read.
// Write lands on the clock edge; read data follows raddr_i combinationally.
// No backpressure; the owner gates we_i.
module fifo_mem #(
    parameter  int DATA_WIDTH = 8,
    parameter  int DEPTH      = 16,
    localparam int ADDR_W     = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [ADDR_W-1:0]     waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [ADDR_W-1:0]     raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    // Storage is intentionally not reset; contents are only meaningful behind the pointers.
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with FWFT option, almost-full/empty thresholds, count, sticky errors, flush.
// Standard mode: data 1 clock after the accepted read; FWFT: head word visible right after the write edge.
// Writes refused while full, reads refused while empty; refusals only set the sticky error flags.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter  int DEPTH      = DEF_DEPTH,
    parameter  int AF_THRESH  = DEPTH - 2,
    parameter  int AE_THRESH  = 2,
    parameter  int FWFT       = 0,
    localparam int ADDR_W     = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  w_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  r_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_W:0]       count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int PTR_W = ptr_width(DEPTH);
    localparam logic [PTR_W-1:0] DEPTH_C = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0] AF_C    = PTR_W'(AF_THRESH);
    localparam logic [PTR_W-1:0] AE_C    = PTR_W'(AE_THRESH);

    if (!params_legal(DEPTH, AF_THRESH, AE_THRESH)) begin : g_bad_params
        $error("sync_fifo_param: DEPTH must be a power of 2 >= 4, AF_THRESH in 1..DEPTH, AE_THRESH in 0..DEPTH-1");
    end

    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]      count_q, count_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  af_q, af_d;
    logic                  ae_q, ae_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;
    logic                  wr_acc, rd_acc;
    logic [DATA_WIDTH-1:0] rdata;

    // Flush outranks both requests, so neither is accepted nor flagged in a flush cycle.
    assign wr_acc = w_en & ~full_q  & ~flush;
    assign rd_acc = r_en & ~empty_q & ~flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(wr_acc);
        rd_ptr_d = rd_ptr_q + PTR_W'(rd_acc);
        ovf_d    = ovf_q | (w_en & full_q  & ~flush);
        unf_d    = unf_q | (r_en & empty_q & ~flush);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            ovf_d    = 1'b0;
            unf_d    = 1'b0;
        end
        // Status is computed from next-state pointers so it is current right after the edge.
        count_d = wr_ptr_d - rd_ptr_d;
        full_d  = (count_d == DEPTH_C);
        empty_d = (count_d == '0);
        af_d    = (count_d >= AF_C);
        ae_d    = (count_d <= AE_C);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            af_q     <= 1'b0;
            ae_q     <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            af_q     <= af_d;
            ae_q     <= ae_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk_i   (clk),
        .we_i    (wr_acc),
        .waddr_i (wr_ptr_q[ADDR_W-1:0]),
        .wdata_i (data_in),
        .raddr_i (rd_ptr_q[ADDR_W-1:0]),
        .rdata_o (rdata)
    );

    if (FWFT != 0) begin : g_fwft
        assign data_out = rdata;
    end else begin : g_std
        logic [DATA_WIDTH-1:0] dout_q, dout_d;

        always_comb begin
            dout_d = dout_q;
            if (rd_acc) begin
                dout_d = rdata;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                dout_q <= '0;
            end else begin
                dout_q <= dout_d;
            end
        end

        assign data_out = dout_q;
    end

    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

endmodule
